// File: rtl/io_cfg_frame_loader_if.sv
// Bus bundle between the configuration frame loader and its surroundings:
// session control, the byte stream, and the grid's bit-programming port.
interface io_cfg_frame_loader_if #(
  parameter int ADDR_WIDTH = 4
);
  // session control and status
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  // configuration byte stream
  logic [7:0]            cfg_byte;
  logic                  cfg_byte_valid;
  logic                  cfg_byte_ready;
  // memory-bank programming port of the I/O grid
  logic                  enable;
  logic [0:ADDR_WIDTH-1] address;
  logic                  data_in;

  // loader side
  modport master (
    input  start, abort, cfg_byte, cfg_byte_valid,
    output cfg_byte_ready, enable, address, data_in, busy, done, aborted
  );

  // sequencer / byte source / grid side
  modport slave (
    output start, abort, cfg_byte, cfg_byte_valid,
    input  cfg_byte_ready, enable, address, data_in, busy, done, aborted
  );
endinterface

// File: rtl/io_cfg_frame_loader.sv
// Configuration frame loader: pulls bytes from a valid/ready stream and
// programs the I/O grid one bit at a time, LSB of each byte first. Every bit
// gets a SETUP cycle (address/data settle, enable low) followed by a single
// STROBE cycle (enable high, address/data held).
module io_cfg_frame_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input logic                   prog_clk,
  input logic                   pReset_n,
  io_cfg_frame_loader_if.master bus
);

  localparam int NUM_BYTES = (2 ** ADDR_WIDTH) / 8;
  localparam int BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int IDX_W     = BC_W + 3;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SETUP, STROBE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            byte_q, byte_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                  enable_q, enable_d;
  logic [0:ADDR_WIDTH-1] addr_q, addr_d;
  logic                  data_q, data_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [2:0]            bit_nxt;

  // Linear bit index -> grid address: address[0] is the bit within the tile,
  // address[1..] carries the tile index with address[1] as its MSB.
  function automatic logic [0:ADDR_WIDTH-1] map_addr(input logic [IDX_W-1:0] idx);
    logic [0:ADDR_WIDTH-1] a;
    a[0] = idx[0];
    for (int k = 1; k < ADDR_WIDTH; k++) begin
      a[k] = idx[ADDR_WIDTH-k];
    end
    return a;
  endfunction

  assign bit_nxt = bit_idx_q + 3'd1;

  // State and output registers; reset drops enable at once, mid-strobe or not.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      enable_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state logic; address/data are only loaded on the way into SETUP.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    aborted_d  = aborted_q;

    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          // abort beats a simultaneous start: the session never begins
          if (bus.start) begin
            aborted_d = 1'b1;
            done_d    = 1'b0;
          end
        end else if (bus.start) begin
          done_d     = 1'b0;
          aborted_d  = 1'b0;
          bit_idx_d  = '0;
          byte_cnt_d = '0;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (bus.cfg_byte_valid) begin
          byte_d    = bus.cfg_byte;
          bit_idx_d = '0;
          addr_d    = map_addr({byte_cnt_q, 3'd0});
          data_d    = bus.cfg_byte[0];
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = STROBE;
        end
      end

      STROBE: begin
        // the strobe in flight always finishes; abort only stops what follows
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (bit_idx_q != 3'd7) begin
          bit_idx_d = bit_nxt;
          addr_d    = map_addr({byte_cnt_q, bit_nxt});
          data_d    = byte_q[bit_nxt];
          state_d   = SETUP;
        end else if (byte_cnt_q != LAST_BYTE) begin
          // completion is tested before the increment so the count never wraps
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // the programming port rests at zero whenever no session is running
    if (state_d == IDLE) begin
      addr_d = '0;
      data_d = 1'b0;
    end
  end

  // enable is a registered copy of "next cycle is STROBE"
  always_comb begin
    enable_d = (state_d == STROBE);
  end

  assign bus.cfg_byte_ready = (state_q == FETCH);
  assign bus.busy           = (state_q != IDLE);
  assign bus.enable         = enable_q;
  assign bus.address        = addr_q;
  assign bus.data_in        = data_q;
  assign bus.done           = done_q;
  assign bus.aborted        = aborted_q;

endmodule

// File: tb/tb_io_cfg_frame_loader.sv
// Directed bench for the configuration frame loader (ADDR_WIDTH = 4).
module tb_io_cfg_frame_loader;

  logic clk;
  logic rst_n;

  io_cfg_frame_loader_if #(.ADDR_WIDTH(4)) bus ();

  io_cfg_frame_loader #(.ADDR_WIDTH(4)) dut (
    .prog_clk (clk),
    .pReset_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int byte_ptr = 0;
  int stall_en = 0;
  int stall_cnt = 0;
  int base = 0;

  logic [7:0]  src [2];
  logic [15:0] exp_data;
  logic [3:0]  exp_addr [16];

  // address viewed as address[0] first
  logic [3:0] addr_flat;
  assign addr_flat = {bus.address[0], bus.address[1], bus.address[2], bus.address[3]};

  // write log: every enable pulse, plus a tally of pulses not preceded by a clean setup
  int         pulse_cnt = 0;
  int         setup_bad = 0;
  logic [3:0] addr_log [256];
  logic       data_log [256];
  logic       prev_en = 1'b0;
  logic [3:0] prev_addr = '0;
  logic       prev_data = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en   <= 1'b0;
      prev_addr <= '0;
      prev_data <= 1'b0;
    end else begin
      if (bus.enable) begin
        if (pulse_cnt < 256) begin
          addr_log[pulse_cnt] <= addr_flat;
          data_log[pulse_cnt] <= bus.data_in;
        end
        pulse_cnt <= pulse_cnt + 1;
        if (prev_en || prev_addr != addr_flat || prev_data != bus.data_in)
          setup_bad <= setup_bad + 1;
      end
      prev_en   <= bus.enable;
      prev_addr <= addr_flat;
      prev_data <= bus.data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; advance the byte source on each handshake, optionally stalling
  task automatic tick();
    logic hs;
    hs = bus.cfg_byte_ready && bus.cfg_byte_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      byte_ptr++;
      if (byte_ptr < 2) bus.cfg_byte = src[byte_ptr];
      if (stall_en != 0 && byte_ptr == 1) begin
        bus.cfg_byte_valid = 1'b0;
        stall_cnt = 0;
      end
    end else if (stall_en != 0 && !bus.cfg_byte_valid && bus.cfg_byte_ready) begin
      stall_cnt++;
      if (stall_cnt == 6) begin
        bus.cfg_byte_valid = 1'b1;
        stall_en = 0;
      end
    end
  endtask

  task automatic start_session();
    byte_ptr = 0;
    bus.cfg_byte = src[0];
    bus.cfg_byte_valid = 1'b1;
    base = pulse_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (!bus.done && cyc < 200) tick();
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy_after"}, bus.busy, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    tick();
    chk({tag, "_pulses"}, pulse_cnt - base, 16);
    chk({tag, "_setup_order"}, setup_bad, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), addr_log[base + k], exp_addr[k]);
      chk($sformatf("%s_data%0d", tag, k), data_log[base + k], exp_data[k]);
    end
  endtask

  initial begin
    src[0] = 8'hA5;
    src[1] = 8'h3C;
    exp_data = 16'h3CA5;
    exp_addr = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0010, 4'b1010, 4'b0011, 4'b1011,
                 4'b0100, 4'b1100, 4'b0101, 4'b1101, 4'b0110, 4'b1110, 4'b0111, 4'b1111};

    // reset, with valid held high
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_byte = 8'h00;
    bus.cfg_byte_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_enable", bus.enable, 1'b0);
    chk("rst_address", addr_flat, 4'b0000);
    chk("rst_data_in", bus.data_in, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_aborted", bus.aborted, 1'b0);
    chk("rst_ready", bus.cfg_byte_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ready", bus.cfg_byte_ready, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_pulses", pulse_cnt, 0);
    $display("step reset/idle done");

    // full session, valid always high
    start_session();
    chk("full_fetch_busy", bus.busy, 1'b1);
    chk("full_fetch_ready", bus.cfg_byte_ready, 1'b1);
    tick();
    chk("full_setup_enable", bus.enable, 1'b0);
    tick();
    chk("full_strobe_enable", bus.enable, 1'b1);
    wait_done("full", 34);
    chk("full_aborted", bus.aborted, 1'b0);
    chk("full_idle_address", addr_flat, 4'b0000);
    check_writes("full");
    $display("step full session done");

    // abort and start together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abst_busy", bus.busy, 1'b0);
    chk("abst_aborted", bus.aborted, 1'b1);
    tick();
    chk("abst_still_idle", bus.busy, 1'b0);
    $display("step abort+start in idle done");

    // stalled source: valid withheld across 5 FETCH cycles before byte 1
    stall_en = 1;
    start_session();
    chk("stall_clears_aborted", bus.aborted, 1'b0);
    while (cyc < 19) tick();
    chk("stall_ready", bus.cfg_byte_ready, 1'b1);
    chk("stall_enable", bus.enable, 1'b0);
    wait_done("stall", 39);
    check_writes("stall");
    $display("step stalled source done");

    // abort in the third SETUP of byte 0
    start_session();
    while (cyc < 5) tick();
    chk("abort_in_setup", bus.enable, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_aborted", bus.aborted, 1'b1);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_enable", bus.enable, 1'b0);
    chk("abort_address", addr_flat, 4'b0000);
    repeat (4) tick();
    chk("abort_pulses", pulse_cnt - base, 2);
    chk("abort_idle_ready", bus.cfg_byte_ready, 1'b0);
    start_session();
    chk("restart_aborted", bus.aborted, 1'b0);
    chk("restart_busy", bus.busy, 1'b1);
    wait_done("restart", 34);
    $display("step abort mid-byte done");

    // start pulsed during the second byte is ignored
    start_session();
    while (cyc < 20) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("busy_start", 34);
    check_writes("busy_start");
    $display("step start while busy done");

    // asynchronous reset while enable is high
    start_session();
    tick();
    tick();
    chk("arst_pre_enable", bus.enable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_enable", bus.enable, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_aborted", bus.aborted, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("arst_pulses", pulse_cnt - base, 0);
    chk("arst_idle_busy", bus.busy, 1'b0);
    chk("arst_idle_done", bus.done, 1'b0);
    $display("step async reset in strobe done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
